win3x3_scan_ctrl: RTL and testbench

//  Sequencer for the 3x3 window generator of the ball-locator average filter.
//  - Accepts the pixel stream and drives shift_clk_en / average_filter_en into the window generator.
//  - Tracks column/row position of every accepted pixel and flags when the 3x3 window holds a full interior neighbourhood.
//  - Emits a one-cycle end-of-frame pulse for the downstream centroid logic.
//  - Integration rule: both line shift RAMs in the window generator must have depth IMG_W.

---
 rtl/win3x3_scan_if.sv | 10 +
 rtl/win3x3_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_win3x3_scan_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/win3x3_scan_if.sv
// Pixel-stream port of win3x3_scan_ctrl.
// A beat transfers on a rising clock edge where in_valid && in_ready; in_sof is qualified by in_valid.
interface win3x3_scan_if;
  logic in_valid;
  logic in_sof;
  logic in_ready;

  modport master (output in_valid, output in_sof, input in_ready);
  modport slave  (input in_valid, input in_sof, output in_ready);
endinterface

// File: rtl/win3x3_scan_ctrl.sv
// Scan sequencer for the 3x3 average-filter window generator (line shift RAMs of depth IMG_W).
// Optional macro FRAME_ERR_EN enables sticky short/long-frame detection on frame_err.
module win3x3_scan_ctrl #(
  parameter  int IMG_W = 640,
  parameter  int IMG_H = 480,
  localparam int CW    = $clog2(IMG_W),
  localparam int RW    = $clog2(IMG_H)
) (
  input  logic           clk_100M,
  input  logic           rst_n,
  input  logic           ctrl_en,
  win3x3_scan_if.slave   pix,
  output logic           shift_clk_en,
  output logic           average_filter_en,
  output logic           win_valid,
  output logic [CW-1:0]  win_x,
  output logic [RW-1:0]  win_y,
  output logic           frame_done,
  output logic           frame_err,
  output logic [1:0]     o_dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_SCAN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_win_valid;
  logic [CW-1:0] r_win_x;
  logic [RW-1:0] r_win_y;
  logic          r_afe;

  logic [1:0]    w_next;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_shift;
  logic          w_last;
  logic [CW-1:0] w_pix_c;
  logic [RW-1:0] w_pix_r;

  // r_col/r_row hold the position the next accepted pixel will take; in_sof forces (0,0).
  always_comb begin
    w_in_ready = (r_state == ST_WAIT) || (r_state == ST_SCAN);
    w_accept   = pix.in_valid && w_in_ready;
    w_pix_c    = pix.in_sof ? '0 : r_col;
    w_pix_r    = pix.in_sof ? '0 : r_row;
    w_shift    = w_accept && ((r_state == ST_SCAN) || pix.in_sof);
    w_last     = (w_pix_c == COL_LAST) && (w_pix_r == ROW_LAST);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: w_next = ST_WAIT;
      ST_WAIT: if (w_shift) w_next = ST_SCAN;
      ST_SCAN: if (w_shift && w_last) w_next = ST_DONE;
      ST_DONE: w_next = ST_WAIT;
      default: w_next = ST_IDLE;
    endcase
    if (!ctrl_en) w_next = ST_IDLE;
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_win_valid <= 1'b0;
      r_win_x     <= '0;
      r_win_y     <= '0;
      r_afe       <= 1'b0;
    end else if (!ctrl_en) begin
      r_state     <= ST_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_win_valid <= 1'b0;
      r_afe       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_afe   <= (w_next != ST_IDLE);
      if (w_shift) begin
        if (w_last) begin
          r_col <= '0;
          r_row <= '0;
        end else if (w_pix_c == COL_LAST) begin
          r_col <= '0;
          r_row <= w_pix_r + 1'b1;
        end else begin
          r_col <= w_pix_c + 1'b1;
          r_row <= w_pix_r;
        end
        // Window is centred one pixel up-left of the newest pixel; borders are never flagged.
        r_win_valid <= (w_pix_c >= CW'(2)) && (w_pix_r >= RW'(2));
        r_win_x     <= w_pix_c - 1'b1;
        r_win_y     <= w_pix_r - 1'b1;
      end else if (w_next != r_state) begin
        r_win_valid <= 1'b0;
      end
    end
  end

`ifdef FRAME_ERR_EN
  logic r_frame_err;
  logic r_after_done;

  // r_after_done marks the WAIT_SOF stretch that directly follows a completed frame.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err  <= 1'b0;
      r_after_done <= 1'b0;
    end else if (!ctrl_en) begin
      r_frame_err  <= 1'b0;
      r_after_done <= 1'b0;
    end else begin
      if (w_accept && (r_state == ST_SCAN) && pix.in_sof)
        r_frame_err <= 1'b1;
      if (w_accept && (r_state == ST_WAIT) && r_after_done && !pix.in_sof)
        r_frame_err <= 1'b1;
      if (r_state == ST_DONE)
        r_after_done <= 1'b1;
      else if (w_shift)
        r_after_done <= 1'b0;
    end
  end

  assign frame_err = r_frame_err;
`else
  assign frame_err = 1'b0;
`endif

  assign pix.in_ready      = w_in_ready;
  assign shift_clk_en      = w_shift;
  assign average_filter_en = r_afe;
  assign win_valid         = r_win_valid;
  assign win_x             = r_win_x;
  assign win_y             = r_win_y;
  assign frame_done        = (r_state == ST_DONE);
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_win3x3_scan_ctrl.sv
// Directed bench for win3x3_scan_ctrl on an 8x6 image.
module tb_win3x3_scan_ctrl;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int CW = 3;
  localparam int RW = 3;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_SCAN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
`ifdef FRAME_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  // clock / reset
  logic clk_100M = 1'b0;
  logic rst_n;
  logic ctrl_en;
  always #5 clk_100M = ~clk_100M;

  logic          shift_clk_en, average_filter_en, win_valid, frame_done, frame_err;
  logic [CW-1:0] win_x;
  logic [RW-1:0] win_y;
  logic [1:0]    dbg_state;

  win3x3_scan_if pix ();

  win3x3_scan_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk_100M          (clk_100M),
    .rst_n             (rst_n),
    .ctrl_en           (ctrl_en),
    .pix               (pix),
    .shift_clk_en      (shift_clk_en),
    .average_filter_en (average_filter_en),
    .win_valid         (win_valid),
    .win_x             (win_x),
    .win_y             (win_y),
    .frame_done        (frame_done),
    .frame_err         (frame_err),
    .o_dbg_state       (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: expected {win_x, win_y} per fresh window
  logic [CW+RW-1:0] exp_q[$];
  logic prev_shift = 1'b0;
  int   wv_cycles  = 0;
  int   fd_count   = 0;

  always @(negedge clk_100M) begin
    if (prev_shift && win_valid) begin
      if (exp_q.size() == 0) check("win_unexp", win_valid, 1'b0);
      else                   check("win_xy", {win_x, win_y}, exp_q.pop_front());
    end
    if (win_valid)  wv_cycles++;
    if (frame_done) fd_count++;
    prev_shift = shift_clk_en;
  end

  // driver tasks
  task automatic drive(input logic v, input logic s, input int exp_sh);
    pix.in_valid = v;
    pix.in_sof   = s;
    #1;
    if (exp_sh >= 0) check("shift_clk_en", shift_clk_en, exp_sh[0]);
    @(posedge clk_100M);
    #1;
  endtask

  task automatic push_win(input int k);
    int c, r;
    logic [CW-1:0] x;
    logic [RW-1:0] y;
    c = k % W;
    r = k / W;
    if (c >= 2 && r >= 2) begin
      x = CW'(c - 1);
      y = RW'(r - 1);
      exp_q.push_back({x, y});
    end
  endtask

  task automatic send_pixels(input int k0, input int n, input bit gap);
    for (int k = k0; k < k0 + n; k++) begin
      push_win(k);
      drive(1'b1, k == 0, 1);
      if (gap) drive(1'b0, 1'b0, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ctrl_en = 1'b0;
    pix.in_valid = 1'b0;
    pix.in_sof = 1'b0;
    repeat (2) @(posedge clk_100M);
    #1;
    check("rst_state", dbg_state, S_IDLE);
    check("rst_ready", pix.in_ready, 1'b0);
    check("rst_afe", average_filter_en, 1'b0);
    check("rst_wv", win_valid, 1'b0);
    check("rst_xy", {win_x, win_y}, 6'd0);
    check("rst_fd", frame_done, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, -1);
    check("idle_hold", dbg_state, S_IDLE);
    ctrl_en = 1'b1;
    drive(1'b0, 1'b0, -1);
    check("en_state", dbg_state, S_WAIT);
    check("en_afe", average_filter_en, 1'b1);
    check("en_ready", pix.in_ready, 1'b1);

    // 1: asynchronous reset in the middle of a frame
    send_pixels(0, 6, 1'b0);
    check("t1_scan", dbg_state, S_SCAN);
    pix.in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_state", dbg_state, S_IDLE);
    check("t1_ready", pix.in_ready, 1'b0);
    check("t1_shift", shift_clk_en, 1'b0);
    check("t1_afe", average_filter_en, 1'b0);
    check("t1_wv", win_valid, 1'b0);
    check("t1_fd", frame_done, 1'b0);
    @(posedge clk_100M);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, -1);
    check("t1_rearm", dbg_state, S_WAIT);

    // 4: beats without sof are dropped in WAIT_SOF
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 0);
      check("t4_ready", pix.in_ready, 1'b1);
      check("t4_state", dbg_state, S_WAIT);
      check("t4_wv", win_valid, 1'b0);
    end

    // 2: back-to-back frame
    wv_cycles = 0;
    fd_count = 0;
    send_pixels(0, W * H, 1'b0);
    check("t2_fd", frame_done, 1'b1);
    check("t2_done", dbg_state, S_DONE);
    check("t2_last_wv", win_valid, 1'b1);
    check("t2_last_xy", {win_x, win_y}, {3'd6, 3'd4});
    drive(1'b0, 1'b0, -1);
    check("t2_fd_off", frame_done, 1'b0);
    check("t2_wait", dbg_state, S_WAIT);
    check("t2_wv_off", win_valid, 1'b0);
    check("t2_wv_cycles", wv_cycles, 24);
    check("t2_fd_count", fd_count, 1);
    check("t2_q_empty", exp_q.size(), 0);

    // 3: same frame with a gap after every beat
    fd_count = 0;
    send_pixels(0, W * H - 1, 1'b1);
    send_pixels(W * H - 1, 1, 1'b0);
    check("t3_fd", frame_done, 1'b1);
    drive(1'b0, 1'b0, -1);
    check("t3_fd_count", fd_count, 1);
    check("t3_q_empty", exp_q.size(), 0);
    check("t3_ferr", frame_err, 1'b0);

    // 5: sof in mid-frame restarts the scan
    fd_count = 0;
    send_pixels(0, 20, 1'b0);
    send_pixels(0, 1, 1'b0);
    check("t5_scan", dbg_state, S_SCAN);
    check("t5_ferr", frame_err, ERR_EN);
    send_pixels(1, W * H - 2, 1'b0);
    check("t5_no_fd", fd_count, 0);
    send_pixels(W * H - 1, 1, 1'b0);
    check("t5_fd", frame_done, 1'b1);
    drive(1'b0, 1'b0, -1);
    check("t5_fd_count", fd_count, 1);
    check("t5_q_empty", exp_q.size(), 0);

    // 6: disable mid-frame, re-enable without sof
    send_pixels(0, 30, 1'b0);
    ctrl_en = 1'b0;
    drive(1'b1, 1'b0, -1);
    check("t6_idle", dbg_state, S_IDLE);
    check("t6_afe", average_filter_en, 1'b0);
    check("t6_wv", win_valid, 1'b0);
    check("t6_ferr", frame_err, 1'b0);
    check("t6_ready", pix.in_ready, 1'b0);
    ctrl_en = 1'b1;
    wv_cycles = 0;
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 0);
    drive(1'b0, 1'b0, -1);
    check("t6_no_win", wv_cycles, 0);
    check("t6_wait", dbg_state, S_WAIT);
    check("t6_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
